uart_bus_bridge: RTL and testbench

- Serial-to-bus master: receives 8N1 command frames on a UART line and issues single 32-bit read/write transactions on a PicoRV32-native memory interface.
- Returns results over its own UART transmitter.
- Counterpart to the SoC's UART slave: lets a host drive the system bus (debug loader, peek/poke) through the same serial link format.

---
 rtl/uart_bus_bridge.sv | 278 +++++++++++++++++++++++++++
 tb/tb_uart_bus_bridge.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// uart_bus_bridge
//
// Serial-to-bus master. A host sends 8N1 command frames on ser_rx; the bridge
// turns each complete command into one 32-bit transaction on a PicoRV32-style
// native memory interface and reports the result on ser_tx.
//
//   'W' A0 A1 A2 A3 D0 D1 D2 D3  -> write, answered with 'K'
//   'R' A0 A1 A2 A3              -> read, answered with the 4 data bytes, LSB first
//   (address and data little-endian; any other first byte is ignored)
//
// Parameters
//   CLK_DIV  clock cycles per serial bit (4 .. 2**20)
//   TIMEOUT  idle cycles allowed between command bytes before a partial
//            command is dropped (>= 1)
//
// Ports
//   clk        system clock
//   resetn     asynchronous active-low reset
//   ser_rx     serial input, idle high, already synchronized to clk
//   ser_tx     serial output, idle high
//   mem_valid  bus request
//   mem_ready  bus completion, honoured only while mem_valid=1
//   mem_addr   word address, bits [1:0] always 0
//   mem_wdata  write data
//   mem_wstrb  4'hF for a write, 4'h0 for a read
//   mem_rdata  read data, valid with mem_ready
//   busy       high whenever the command parser is not idle
// -----------------------------------------------------------------------------
module uart_bus_bridge #(
    parameter int CLK_DIV = 139,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ser_rx,
    output logic        ser_tx,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    // Counter widths hold the compare values without wrapping.
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RESP_ACK  = 8'h4B;

    // -------------------------------------------------------------------------
    // UART receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     rx_state;
    logic [DW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;   // holds the received byte while rx_valid is high
    logic          rx_valid;   // one-cycle pulse: byte with a good stop bit
    logic          rx_ferr;    // one-cycle pulse: stop bit sampled low

    // NOTE: state registers use non-blocking assignments so every flop in the
    // block samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!ser_rx) begin
                        rx_state <= RX_START;
                        rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Re-check the line half a bit in; a high here was a glitch.
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= ser_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_shift <= {ser_rx, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
                            rx_state <= RX_STOP;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == DIV_LAST) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (ser_rx) begin
                            rx_valid <= 1'b1;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // UART transmitter
    // -------------------------------------------------------------------------
    logic          tx_active;
    logic [DW-1:0] tx_cnt;
    logic [3:0]    tx_bit;     // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]    tx_shift;   // remaining data bits with the stop bit on top
    logic          tx_ready;
    logic          tx_load;
    logic [7:0]    tx_byte;

    // Ready in the final cycle of a stop bit as well, so a queued byte's start
    // bit follows the previous stop bit with no idle gap.
    assign tx_ready = !tx_active || (tx_bit == 4'd9 && tx_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ser_tx    <= 1'b1;
            tx_active <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
        end else if (tx_load) begin
            ser_tx    <= 1'b0;
            tx_shift  <= {1'b1, tx_byte};
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_active <= 1'b1;
        end else if (tx_active) begin
            if (tx_cnt == DIV_LAST) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                end else begin
                    ser_tx   <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[8:1]};
                    tx_bit   <= tx_bit + 1'b1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Command parser and bus master
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_WDATA, P_BUS, P_RESP} p_state_t;

    p_state_t      p_state;
    logic          is_write;
    logic [1:0]    byte_idx;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [2:0]    resp_idx;
    logic [2:0]    resp_len;
    logic [TW-1:0] tmo_cnt;

    assign resp_len = is_write ? 3'd1 : 3'd4;
    assign tx_load  = (p_state == P_RESP) && (resp_idx != resp_len) && tx_ready;
    assign tx_byte  = is_write ? RESP_ACK : rdata[{resp_idx[1:0], 3'b000} +: 8];

    // NOTE: the command/data registers are reset along with the control state
    // because mem_addr/mem_wdata have defined reset values and they are few flops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p_state   <= P_IDLE;
            busy      <= 1'b0;
            is_write  <= 1'b0;
            byte_idx  <= '0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
            resp_idx  <= '0;
            tmo_cnt   <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            case (p_state)
                P_IDLE: begin
                    if (rx_valid && (rx_shift == CMD_WRITE || rx_shift == CMD_READ)) begin
                        is_write <= (rx_shift == CMD_WRITE);
                        byte_idx <= '0;
                        tmo_cnt  <= '0;
                        p_state  <= P_ADDR;
                        busy     <= 1'b1;
                    end
                end
                P_ADDR, P_WDATA: begin
                    if (rx_ferr) begin
                        p_state <= P_IDLE;
                        busy    <= 1'b0;
                    end else if (rx_valid) begin
                        tmo_cnt  <= '0;
                        byte_idx <= byte_idx + 1'b1;
                        if (p_state == P_ADDR) begin
                            addr[{byte_idx, 3'b000} +: 8] <= rx_shift;
                        end else begin
                            wdata[{byte_idx, 3'b000} +: 8] <= rx_shift;
                        end
                        if (byte_idx == 2'd3) begin
                            p_state <= (p_state == P_ADDR && is_write) ? P_WDATA : P_BUS;
                        end
                    end else if (tmo_cnt >= TMO_LAST) begin
                        tmo_cnt <= TMO_MAX;
                        p_state <= P_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                P_BUS: begin
                    // mem_valid is low only in the first BUS cycle: issue the request.
                    if (!mem_valid) begin
                        mem_valid <= 1'b1;
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_wdata <= is_write ? wdata : 32'h0;
                        mem_wstrb <= is_write ? 4'hF : 4'h0;
                    end else if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if (!is_write) begin
                            rdata <= mem_rdata;
                        end
                        resp_idx <= '0;
                        p_state  <= P_RESP;
                    end
                end
                P_RESP: begin
                    if (tx_load) begin
                        resp_idx <= resp_idx + 1'b1;
                    end else if (resp_idx == resp_len && tx_ready) begin
                        p_state <= P_IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    p_state <= P_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_bus_bridge
//
// Host-side UART driver, a bus responder and a UART frame monitor around
// uart_bus_bridge. Expected bus transactions and response bytes are queued
// when a command is sent and checked when the bridge produces them.
// -----------------------------------------------------------------------------
module tb_uart_bus_bridge;

    localparam int CLK_DIV     = 16;
    localparam int TIMEOUT     = 1000;
    localparam int READY_DELAY = 3;
    localparam int IDLE_BUDGET = 6000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
    } bus_exp_t;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_rx = 1'b1;
    logic        ser_tx;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        busy;

    logic rsp_ready   = 1'b0;
    logic stray_ready = 1'b0;
    assign mem_ready = rsp_ready | stray_ready;

    int checks = 0;
    int errors = 0;

    bus_exp_t   exp_bus[$];
    logic [7:0] exp_tx[$];
    logic [7:0] host_q[$];

    int cyc         = 0;
    int first_start = -1;
    int busy_fall   = -1;
    logic busy_q    = 1'b0;
    bit tx_mon_busy = 1'b0;
    bit bus_active  = 1'b0;
    bit bus_hold    = 1'b0;
    int bus_count   = 0;

    uart_bus_bridge #(
        .CLK_DIV (CLK_DIV),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .ser_rx    (ser_rx),
        .ser_tx    (ser_tx),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy_q === 1'b1 && busy === 1'b0) busy_fall = cyc;
        busy_q = busy;
    end

    // UART frame monitor on ser_tx: exact bit timing plus decoded value.
    initial begin : tx_monitor
        logic [7:0] exp_b;
        logic [7:0] got;
        logic [9:0] frame;
        int bad;
        forever begin
            @(negedge clk);
            if (ser_tx === 1'b0) begin
                tx_mon_busy = 1'b1;
                if (first_start < 0) first_start = cyc;
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: frame started at cycle %0d with nothing expected", cyc);
                    exp_b = 8'h00;
                end else begin
                    exp_b = exp_tx.pop_front();
                end
                frame = {1'b1, exp_b, 1'b0};
                bad   = 0;
                got   = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CLK_DIV; c++) begin
                        if (ser_tx !== frame[b]) bad++;
                        if (c == CLK_DIV / 2 && b >= 1 && b <= 8) got[b-1] = ser_tx;
                        if (!(b == 9 && c == CLK_DIV - 1)) @(negedge clk);
                    end
                end
                checks++;
                if (got !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte: got %h expected %h", got, exp_b);
                end
                checks++;
                if (bad != 0) begin
                    errors++;
                    $display("FAIL tx_timing: %0d of %0d samples off for byte %h", bad, 10 * CLK_DIV, exp_b);
                end
                tx_mon_busy = 1'b0;
            end
        end
    end

    // Bus responder: checks each request against the scoreboard, completes it
    // READY_DELAY cycles later unless bus_hold is set.
    initial begin : bus_responder
        bus_exp_t    e;
        logic [31:0] a;
        logic [31:0] w;
        logic [3:0]  s;
        bit          stable;
        forever begin
            @(negedge clk);
            if (mem_valid === 1'b1) begin
                bus_active = 1'b1;
                bus_count++;
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_unexpected: addr %h wstrb %h", mem_addr, mem_wstrb);
                    e = '{default: '0};
                end else begin
                    e = exp_bus.pop_front();
                end
                checks++;
                if (mem_addr !== e.addr) begin
                    errors++;
                    $display("FAIL bus_addr: got %h expected %h", mem_addr, e.addr);
                end
                checks++;
                if (mem_wstrb !== e.wstrb) begin
                    errors++;
                    $display("FAIL bus_wstrb: got %h expected %h", mem_wstrb, e.wstrb);
                end
                if (e.wstrb == 4'hF) begin
                    checks++;
                    if (mem_wdata !== e.wdata) begin
                        errors++;
                        $display("FAIL bus_wdata: got %h expected %h", mem_wdata, e.wdata);
                    end
                end
                a = mem_addr;
                w = mem_wdata;
                s = mem_wstrb;
                stable = 1'b1;
                for (int i = 0; i < READY_DELAY; i++) begin
                    @(negedge clk);
                    if (mem_valid !== 1'b1 || mem_addr !== a || mem_wdata !== w || mem_wstrb !== s) stable = 1'b0;
                end
                while (bus_hold && mem_valid === 1'b1) @(negedge clk);
                if (!bus_hold || mem_valid === 1'b1) begin
                    checks++;
                    if (!stable) begin
                        errors++;
                        $display("FAIL bus_stable: request changed or dropped before mem_ready (addr now %h)", mem_addr);
                    end
                    rsp_ready = 1'b1;
                    mem_rdata = e.rdata;
                    @(negedge clk);
                    rsp_ready = 1'b0;
                    mem_rdata = '0;
                    checks++;
                    if (mem_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL bus_release: mem_valid %b expected 0 after mem_ready", mem_valid);
                    end
                end
                bus_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------------------------------------------------------- helpers
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        ser_rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            repeat (CLK_DIV) @(negedge clk);
        end
        ser_rx = stop_bit;
        repeat (CLK_DIV) @(negedge clk);
        ser_rx = 1'b1;
    endtask

    task automatic send_queue();
        logic [7:0] b;
        while (host_q.size() > 0) begin
            b = host_q.pop_front();
            send_byte(b, 1'b1);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || exp_tx.size() != 0 || exp_bus.size() != 0 || tx_mon_busy || bus_active)
               && n < IDLE_BUDGET) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= IDLE_BUDGET) begin
            errors++;
            $display("FAIL %s_idle: busy %b, %0d tx bytes and %0d bus requests still pending",
                     name, busy, exp_tx.size(), exp_bus.size());
            exp_tx.delete();
            exp_bus.delete();
        end
        repeat (4) @(negedge clk);
    endtask

    // Queue the expectations and host bytes of a complete read command.
    task automatic queue_read(input logic [31:0] a, input logic [31:0] rd);
        exp_bus.push_back('{addr: {a[31:2], 2'b00}, wdata: 32'h0, wstrb: 4'h0, rdata: rd});
        for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
        host_q.push_back(8'h52);
        for (int i = 0; i < 4; i++) host_q.push_back(a[8*i +: 8]);
    endtask

    task automatic queue_write(input logic [31:0] a, input logic [31:0] wd, input bit expect_ack);
        exp_bus.push_back('{addr: {a[31:2], 2'b00}, wdata: wd, wstrb: 4'hF, rdata: 32'h0});
        if (expect_ack) exp_tx.push_back(8'h4B);
        host_q.push_back(8'h57);
        for (int i = 0; i < 4; i++) host_q.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) host_q.push_back(wd[8*i +: 8]);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ser_tx !== 1'b1)     begin errors++; $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); end
        checks++; if (mem_valid !== 1'b0)  begin errors++; $display("FAIL reset_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (mem_addr !== 32'h0)  begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (mem_wstrb !== 4'h0)  begin errors++; $display("FAIL reset_mem_wstrb: got %h expected 0", mem_wstrb); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        resetn = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_write();
        queue_write(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        send_queue();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL write_busy: got %b expected 1", busy); end
        wait_idle("write");
    endtask

    task automatic test_read();
        queue_read(32'h0000_0103, 32'h1234_5678);
        first_start = -1;
        busy_fall   = -1;
        send_queue();
        wait_idle("read");
        checks++;
        if (busy_fall - first_start != 10 * CLK_DIV * 4) begin
            errors++;
            $display("FAIL read_resp_length: got %0d cycles expected %0d", busy_fall - first_start, 40 * CLK_DIV);
        end
    endtask

    task automatic test_glitch_bad_cmd();
        int n0 = bus_count;
        ser_rx = 1'b0;
        repeat (4) @(negedge clk);
        ser_rx = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        stray_ready = 1'b1;
        repeat (3) @(negedge clk);
        stray_ready = 1'b0;
        send_byte(8'h41, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bad_cmd_busy: got %b expected 0", busy); end
        checks++;
        if (bus_count != n0) begin errors++; $display("FAIL glitch_bus: got %0d requests expected 0", bus_count - n0); end
        queue_write(32'h0000_0020, 32'h0BAD_F00D, 1'b1);
        send_queue();
        wait_idle("after_glitch");
    endtask

    task automatic test_timeout();
        int n0 = bus_count;
        host_q = '{8'h52, 8'h00};
        send_queue();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL timeout_partial_busy: got %b expected 1", busy); end
        repeat (930) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL timeout_early: busy %b expected 1 before the limit", busy); end
        repeat (80) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL timeout_expire: busy %b expected 0 after the limit", busy); end
        checks++;
        if (bus_count != n0) begin errors++; $display("FAIL timeout_bus: got %0d requests expected 0", bus_count - n0); end
        queue_read(32'h4433_2211, 32'hA5C3_0F81);
        send_queue();
        wait_idle("after_timeout");
    endtask

    task automatic test_framing();
        int n0 = bus_count;
        send_byte(8'h57, 1'b1);
        repeat (2) @(negedge clk);
        send_byte(8'h01, 1'b1);
        repeat (2) @(negedge clk);
        send_byte(8'h02, 1'b0);
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL framing_busy: got %b expected 0", busy); end
        checks++;
        if (bus_count != n0) begin errors++; $display("FAIL framing_bus: got %0d requests expected 0", bus_count - n0); end
        queue_write(32'h0000_0080, 32'h0102_0304, 1'b1);
        send_queue();
        wait_idle("after_framing");
    endtask

    task automatic test_reset_in_bus();
        int n = 0;
        bus_hold = 1'b1;
        queue_write(32'h0000_0300, 32'h55AA_55AA, 1'b0);
        send_queue();
        while (mem_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_valid !== 1'b1) begin errors++; $display("FAIL hold_request: mem_valid %b expected 1", mem_valid); end
        repeat (5) @(negedge clk);
        #3;
        resetn = 1'b0;
        #1;
        checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL async_mem_valid: got %b expected 0", mem_valid); end
        checks++; if (ser_tx !== 1'b1)    begin errors++; $display("FAIL async_ser_tx: got %b expected 1", ser_tx); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL async_busy: got %b expected 0", busy); end
        @(negedge clk);
        bus_hold = 1'b0;
        exp_bus.delete();
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        queue_read(32'h0000_0200, 32'hCAFE_F00D);
        send_queue();
        wait_idle("after_reset");
    endtask

    initial begin : main
        test_reset();
        test_write();
        test_read();
        test_glitch_bad_cmd();
        test_timeout();
        test_framing();
        test_reset_in_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
